// File: rtl/elbeth_fetch_pkg.sv
// ============================================================================
// Module : elbeth_fetch_pkg
// Brief  : Shared fetch-stage definitions: FSM encodings, field layout, NOP.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package elbeth_fetch_pkg;

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FULL  = 2'd3;

    // Field bit ranges, shared with the decoder.
    localparam int OPCODE_MSB = 6;
    localparam int OPCODE_LSB = 0;
    localparam int INST0_MSB  = 11;
    localparam int INST0_LSB  = 7;
    localparam int INST1_MSB  = 14;
    localparam int INST1_LSB  = 12;
    localparam int INST2_MSB  = 19;
    localparam int INST2_LSB  = 15;
    localparam int INST3_MSB  = 24;
    localparam int INST3_LSB  = 20;
    localparam int INST4_MSB  = 31;
    localparam int INST4_LSB  = 25;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef struct packed {
        logic [6:0] inst_4;
        logic [4:0] inst_3;
        logic [4:0] inst_2;
        logic [2:0] inst_1;
        logic [4:0] inst_0;
        logic [6:0] opcode;
    } fetch_fields_t;

    function automatic fetch_fields_t split_instr(input logic [31:0] word);
        return fetch_fields_t'(word);
    endfunction

endpackage

`default_nettype wire

// File: rtl/elbeth_fetch_skid.sv
// ============================================================================
// Module : elbeth_fetch_skid
// Brief  : One-entry {pc, word} skid buffer with load / unload / flush.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elbeth_fetch_skid #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic            unload_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     word_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [31:0]     word_o
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     word_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            word_q  <= '0;
        end else begin
            if (flush_i || unload_i) begin
                valid_q <= 1'b0;
            end else if (load_i) begin
                valid_q <= 1'b1;
            end
            if (load_i) begin
                pc_q   <= pc_i;
                word_q <= word_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign word_o  = word_q;

endmodule

`default_nettype wire

// File: rtl/elbeth_fetch.sv
// ============================================================================
// Module : elbeth_fetch
// Brief  : RV32I instruction fetch: PC, imem req/ack, skid, redirect flush.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module elbeth_fetch
    import elbeth_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            id_stall,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic            if_valid,
    output logic [XLEN-1:0] if_pc,
    output logic [6:0]      opcode,
    output logic [4:0]      inst_0,
    output logic [2:0]      inst_1,
    output logic [4:0]      inst_2,
    output logic [4:0]      inst_3,
    output logic [6:0]      inst_4
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] drain_addr_q, drain_addr_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [31:0]     out_word_q, out_word_d;

    logic            w_ack_fetch;
    logic            w_out_free;
    logic            w_skid_load;
    logic            w_skid_unload;
    logic            w_skid_valid;
    logic [XLEN-1:0] w_skid_pc;
    logic [31:0]     w_skid_word;
    logic [XLEN-1:0] w_target;
    fetch_fields_t   w_fields;

    assign w_target      = branch_target & ~XLEN'(3);
    assign w_ack_fetch   = (state_q == S_FETCH) && imem_ack;
    assign w_out_free    = !valid_q || !id_stall;
    assign w_skid_load   = w_ack_fetch && !w_out_free && !branch_taken;
    assign w_skid_unload = (state_q == S_FULL) && w_skid_valid && !id_stall && !branch_taken;

    elbeth_fetch_skid #(
        .XLEN (XLEN)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .load_i   (w_skid_load),
        .unload_i (w_skid_unload),
        .flush_i  (branch_taken),
        .pc_i     (pc_q),
        .word_i   (imem_rdata),
        .valid_o  (w_skid_valid),
        .pc_o     (w_skid_pc),
        .word_o   (w_skid_word)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        case (state_q)
            S_BOOT: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack && !branch_taken) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = w_out_free ? S_FETCH : S_FULL;
                end else if (branch_taken && !imem_ack) begin
                    // The outstanding request must complete at its original address.
                    state_d      = S_DRAIN;
                    drain_addr_d = pc_q;
                end
            end
            S_DRAIN: if (imem_ack) state_d = S_FETCH;
            S_FULL:  if (!id_stall) state_d = S_FETCH;
            default: state_d = S_BOOT;
        endcase
        if (branch_taken) begin
            pc_d = w_target;
            if (state_q == S_BOOT || state_q == S_FULL) begin
                state_d = S_FETCH;
            end
        end
    end

    always_comb begin
        valid_d    = valid_q;
        out_pc_d   = out_pc_q;
        out_word_d = out_word_q;
        if (branch_taken) begin
            valid_d = 1'b0;
        end else if (w_skid_unload) begin
            valid_d    = 1'b1;
            out_pc_d   = w_skid_pc;
            out_word_d = w_skid_word;
        end else if (w_ack_fetch && w_out_free) begin
            valid_d    = 1'b1;
            out_pc_d   = pc_q;
            out_word_d = imem_rdata;
        end else if (!id_stall) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_BOOT;
            pc_q         <= XLEN'(RESET_PC);
            drain_addr_q <= XLEN'(RESET_PC);
            valid_q      <= 1'b0;
            out_pc_q     <= '0;
            out_word_q   <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            valid_q      <= valid_d;
            out_pc_q     <= out_pc_d;
            out_word_q   <= out_word_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

    assign w_fields = split_instr(out_word_q);
    assign if_valid = valid_q;
    assign if_pc    = out_pc_q;
    assign opcode   = w_fields.opcode;
    assign inst_0   = w_fields.inst_0;
    assign inst_1   = w_fields.inst_1;
    assign inst_2   = w_fields.inst_2;
    assign inst_3   = w_fields.inst_3;
    assign inst_4   = w_fields.inst_4;

endmodule

`default_nettype wire

// File: tb/tb_elbeth_fetch.sv
// ============================================================================
// Module : tb_elbeth_fetch
// Brief  : Self-checking bench for elbeth_fetch with an in-order scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_elbeth_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        id_stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [6:0]  opcode;
    logic [4:0]  inst_0;
    logic [2:0]  inst_1;
    logic [4:0]  inst_2;
    logic [4:0]  inst_3;
    logic [6:0]  inst_4;

    elbeth_fetch #(
        .RESET_PC (32'h0000_0000),
        .XLEN     (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .id_stall      (id_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .if_valid      (if_valid),
        .if_pc         (if_pc),
        .opcode        (opcode),
        .inst_0        (inst_0),
        .inst_1        (inst_1),
        .inst_2        (inst_2),
        .inst_3        (inst_3),
        .inst_4        (inst_4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   mem_lat = 0;
    int   lat_cnt = 0;
    bit   discard_next = 1'b0;
    bit   ack_idle = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0000_0200) ? 32'h00B5_0533 : a;
    endfunction

    // One clock cycle, entered and left at a falling edge.
    task automatic cycle();
        exp_t        e;
        logic [31:0] got;
        if (if_valid === 1'b1 && !id_stall) begin
            n_cmp++;
            got = {inst_4, inst_3, inst_2, inst_1, inst_0, opcode};
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected: got pc=%h word=%h, required no instruction", if_pc, got);
            end else begin
                e = sb.pop_front();
                if (if_pc !== e.pc || got !== e.word) begin
                    n_err++;
                    $display("FAIL sb_instr: got pc=%h word=%h, required pc=%h word=%h",
                             if_pc, got, e.pc, e.word);
                end
            end
        end
        imem_ack = 1'b0;
        if (imem_req === 1'b1) begin
            if (lat_cnt >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_word(imem_addr);
                lat_cnt    = 0;
                if (!branch_taken && !discard_next) sb.push_back('{imem_addr, mem_word(imem_addr)});
                discard_next = 1'b0;
            end else begin
                lat_cnt++;
                if (branch_taken) discard_next = 1'b1;
            end
        end else if (ack_idle) begin
            imem_ack   = 1'b1;
            imem_rdata = 32'hDEAD_BEEF;
        end
        if (branch_taken) sb.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic hold_reset();
        @(negedge clk);
        rst = 1'b1;
        id_stall = 1'b0;
        branch_taken = 1'b0;
        imem_ack = 1'b0;
        sb.delete();
        lat_cnt = 0;
        discard_next = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        mem_lat = 0;
        hold_reset();
        n_cmp++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || {inst_4, inst_3, inst_2, inst_1, inst_0, opcode} !== 32'h0
            || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: got valid=%b pc=%h req=%b addr=%h, required 0/0/0/0",
                     if_valid, if_pc, imem_req, imem_addr);
        end
        ack_idle = 1'b1;
        rst = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL boot_req: got %b, required 0", imem_req);
        end
        cycle();
        ack_idle = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin
                n_err++;
                $display("FAIL stream_addr: got req=%b addr=%h, required 1/%h", imem_req, imem_addr, 32'(4 * k));
            end
            n_cmp++;
            if (if_valid !== (k > 0) || (k > 0 && if_pc !== 32'(4 * (k - 1)))) begin
                n_err++;
                $display("FAIL stream_out: got valid=%b pc=%h at step %0d", if_valid, if_pc, k);
            end
            cycle();
        end
        n_cmp++;
        if (if_valid !== 1'b1 || if_pc !== 32'h8) begin
            n_err++;
            $display("FAIL stream_pc8: got valid=%b pc=%h, required 1/00000008", if_valid, if_pc);
        end
    endtask

    task automatic test_field_split();
        mem_lat = 0;
        hold_reset();
        rst = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0203;
        cycle();
        branch_taken = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
            n_err++;
            $display("FAIL boot_redirect: got req=%b addr=%h, required 1/00000200", imem_req, imem_addr);
        end
        cycle();
        n_cmp++;
        if (if_valid !== 1'b1 || if_pc !== 32'h200 || opcode !== 7'h33 || inst_0 !== 5'd10 || inst_1 !== 3'd0
            || inst_2 !== 5'd10 || inst_3 !== 5'd11 || inst_4 !== 7'd0) begin
            n_err++;
            $display("FAIL field_split: got v=%b pc=%h op=%h i0=%0d i1=%0d i2=%0d i3=%0d i4=%0d, required 1 200 33 10 0 10 11 0",
                     if_valid, if_pc, opcode, inst_0, inst_1, inst_2, inst_3, inst_4);
        end
        cycle();
    endtask

    task automatic test_wrap();
        mem_lat = 0;
        hold_reset();
        rst = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFE;
        cycle();
        branch_taken = 1'b0;
        n_cmp++;
        if (imem_addr !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_target: got addr=%h, required fffffffc", imem_addr);
        end
        cycle();
        n_cmp++;
        if (imem_addr !== 32'h0 || if_pc !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap_addr: got addr=%h pc=%h, required 00000000/fffffffc", imem_addr, if_pc);
        end
        repeat (2) cycle();
    endtask

    task automatic test_stall_skid();
        mem_lat = 0;
        hold_reset();
        rst = 1'b0;
        repeat (4) cycle();
        n_cmp++;
        if (if_pc !== 32'h8 || imem_addr !== 32'hC) begin
            n_err++;
            $display("FAIL pre_stall: got pc=%h addr=%h, required 00000008/0000000c", if_pc, imem_addr);
        end
        id_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle();
            n_cmp++;
            if (if_valid !== 1'b1 || if_pc !== 32'h8 || imem_req !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold: got valid=%b pc=%h req=%b, required 1/00000008/0", if_valid, if_pc, imem_req);
            end
        end
        id_stall = 1'b0;
        cycle();
        n_cmp++;
        if (if_pc !== 32'hC || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            n_err++;
            $display("FAIL skid_release: got pc=%h req=%b addr=%h, required 0000000c/1/00000010", if_pc, imem_req, imem_addr);
        end
        cycle();
        n_cmp++;
        if (if_pc !== 32'h10 || if_valid !== 1'b1) begin
            n_err++;
            $display("FAIL after_skid: got valid=%b pc=%h, required 1/00000010", if_valid, if_pc);
        end
        repeat (2) cycle();
    endtask

    task automatic test_redirect_drain();
        bit seen;
        mem_lat = 2;
        hold_reset();
        rst = 1'b0;
        repeat (5) cycle();
        branch_taken = 1'b1;
        branch_target = 32'h0000_0102;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
            n_err++;
            $display("FAIL pre_drain: got req=%b addr=%h, required 1/00000004", imem_req, imem_addr);
        end
        cycle();
        branch_taken = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h4 || if_valid !== 1'b0) begin
            n_err++;
            $display("FAIL drain_hold: got req=%b addr=%h valid=%b, required 1/00000004/0", imem_req, imem_addr, if_valid);
        end
        cycle();
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_err++;
            $display("FAIL drain_target: got req=%b addr=%h, required 1/00000100", imem_req, imem_addr);
        end
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (if_valid === 1'b1) seen = 1'b1;
            else cycle();
        end
        n_cmp++;
        if (!seen || if_pc !== 32'h100) begin
            n_err++;
            $display("FAIL drain_first: got seen=%b pc=%h, required 1/00000100", seen, if_pc);
        end
        repeat (4) cycle();
    endtask

    task automatic test_redirect_ack_stall();
        mem_lat = 0;
        hold_reset();
        rst = 1'b0;
        repeat (2) cycle();
        n_cmp++;
        if (if_valid !== 1'b1 || imem_req !== 1'b1) begin
            n_err++;
            $display("FAIL pre_coincident: got valid=%b req=%b, required 1/1", if_valid, imem_req);
        end
        id_stall = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0300;
        cycle();
        branch_taken = 1'b0;
        id_stall = 1'b0;
        n_cmp++;
        if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
            n_err++;
            $display("FAIL coincident_flush: got valid=%b req=%b addr=%h, required 0/1/00000300", if_valid, imem_req, imem_addr);
        end
        cycle();
        n_cmp++;
        if (if_valid !== 1'b1 || if_pc !== 32'h300) begin
            n_err++;
            $display("FAIL coincident_next: got valid=%b pc=%h, required 1/00000300", if_valid, if_pc);
        end
        repeat (3) cycle();
    endtask

    task automatic test_async_reset_drain();
        bit seen;
        mem_lat = 2;
        hold_reset();
        rst = 1'b0;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0500;
        cycle();
        branch_taken = 1'b0;
        repeat (4) cycle();
        branch_taken = 1'b1;
        branch_target = 32'h0000_0600;
        cycle();
        branch_taken = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h504) begin
            n_err++;
            $display("FAIL async_pre: got req=%b addr=%h, required 1/00000504", imem_req, imem_addr);
        end
        #2;
        rst = 1'b1;
        imem_ack = 1'b1;
        #1;
        n_cmp++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || {inst_4, inst_3, inst_2, inst_1, inst_0, opcode} !== 32'h0
            || imem_req !== 1'b0 || imem_addr !== 32'h0) begin
            n_err++;
            $display("FAIL async_clear: got valid=%b pc=%h req=%b addr=%h, required 0/0/0/0",
                     if_valid, if_pc, imem_req, imem_addr);
        end
        @(posedge clk);
        @(negedge clk);
        sb.delete();
        lat_cnt = 0;
        discard_next = 1'b0;
        ack_idle = 1'b1;
        rst = 1'b0;
        cycle();
        ack_idle = 1'b0;
        n_cmp++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || if_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_restart: got req=%b addr=%h valid=%b, required 1/00000000/0", imem_req, imem_addr, if_valid);
        end
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (if_valid === 1'b1) seen = 1'b1;
            else cycle();
        end
        n_cmp++;
        if (!seen || if_pc !== 32'h0) begin
            n_err++;
            $display("FAIL async_first: got seen=%b pc=%h, required 1/00000000", seen, if_pc);
        end
        repeat (4) cycle();
    endtask

    initial begin
        test_reset();
        test_field_split();
        test_wrap();
        test_stall_skid();
        test_redirect_drain();
        test_redirect_ack_stall();
        test_async_reset_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
